// File: rtl/pio_bank.sv
// pio_bank: multi-channel Avalon-MM output PIO with per-channel bit set/clear,
// optional shadow/commit staging and a one-cycle update strobe per channel.
module pio_bank #(
    parameter int unsigned DATA_W      = 27,
    parameter int unsigned CHANNELS    = 4,
    parameter logic [31:0] RESET_VALUE = 32'd35025,
    parameter bit          SHADOW      = 1'b1,
    parameter int unsigned ADDR_W      = $clog2(CHANNELS) + 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic [CHANNELS*DATA_W-1:0]   out_port,
    output logic [CHANNELS-1:0]          out_update
);

    localparam logic [DATA_W-1:0] RstVal = RESET_VALUE[DATA_W-1:0];

    logic [DATA_W-1:0]   shadow_q [CHANNELS];
    logic [DATA_W-1:0]   shadow_d [CHANNELS];
    logic [DATA_W-1:0]   active_q [CHANNELS];
    logic [DATA_W-1:0]   active_d [CHANNELS];
    logic [CHANNELS-1:0] update_q;
    logic [CHANNELS-1:0] update_d;

    logic [ADDR_W-1:0]   ch_idx;
    logic [1:0]          reg_sel;
    logic                wr_en;
    logic [DATA_W-1:0]   wd;
    logic                unused_wd_hi;

    assign ch_idx  = address >> 2;
    assign reg_sel = address[1:0];
    assign wr_en   = chipselect && !write_n;
    assign wd      = writedata[DATA_W-1:0];
    // Bits of writedata above DATA_W are deliberately dropped.
    assign unused_wd_hi = ^writedata;

    // Next-state: read-modify-write of the addressed shadow, load of active on commit
    // (or on any shadow write when staging is disabled). Out-of-range channels match nothing.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        update_d = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (wr_en && (32'(ch_idx) == k)) begin
                unique case (reg_sel)
                    2'd0: shadow_d[k] = wd;
                    2'd1: shadow_d[k] = shadow_q[k] | wd;
                    2'd2: shadow_d[k] = shadow_q[k] & ~wd;
                    2'd3: begin
                        active_d[k] = shadow_q[k];
                        update_d[k] = 1'b1;
                    end
                endcase
                if (!SHADOW && (reg_sel != 2'd3)) begin
                    active_d[k] = shadow_d[k];
                    update_d[k] = 1'b1;
                end
            end
        end
    end

    // State registers; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                shadow_q[k] <= RstVal;
                active_q[k] <= RstVal;
            end
            update_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            update_q <= update_d;
        end
    end

    // Flatten active registers onto out_port.
    always_comb begin
        out_port = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            out_port[k*DATA_W +: DATA_W] = active_q[k];
        end
    end

    assign out_update = update_q;

    // Combinational read, independent of chipselect; zero for out-of-range channels.
    always_comb begin
        readdata = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (32'(ch_idx) == k) begin
                if (reg_sel == 2'd3) begin
                    readdata[DATA_W-1:0] = active_q[k];
                end else begin
                    readdata[DATA_W-1:0] = shadow_q[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pio_bank.sv
// tb_pio_bank: scoreboard-driven bench for pio_bank covering shadow/commit,
// set/clear, truncation, back-to-back strobes, direct mode, range and reset priority.
module tb_pio_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   address;
    logic [2:0]   cs;
    logic         write_n;
    logic [31:0]  writedata;

    logic [31:0]  rd0, rd1, rd2;
    logic [107:0] op0, op1;
    logic [80:0]  op2;
    logic [3:0]   up0, up1;
    logic [2:0]   up2;

    logic [127:0] exp_q [$];
    logic [127:0] exp_v;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    // Default: 4 channels, shadowed.
    pio_bank u_dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs[0]),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd0),
        .out_port   (op0),
        .out_update (up0)
    );

    // Direct mode, 4 channels.
    pio_bank #(.SHADOW(1'b0)) u_dut_ns (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs[1]),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd1),
        .out_port   (op1),
        .out_update (up1)
    );

    // Direct mode, 3 channels (channel 3 out of range).
    pio_bank #(.SHADOW(1'b0), .CHANNELS(3)) u_dut_c3 (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs[2]),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd2),
        .out_port   (op2),
        .out_update (up2)
    );

    // Drive one write at the next edge; returns 1ns after that edge with the bus still driven.
    task automatic bus_write(input int sel, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        cs        = 3'b001 << sel;
        write_n   = 1'b0;
        address   = addr;
        writedata = data;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input logic [3:0] addr);
        @(negedge clk);
        cs      = 3'b000;
        write_n = 1'b1;
        address = addr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        address = 4'd0;
        exp_q.push_back(128'({4{27'h88D1}}));
        exp_q.push_back(128'(4'b0000));
        exp_q.push_back(128'(32'h0000_88D1));
        exp_q.push_back(128'(32'h0000_88D1));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op0) !== exp_v) begin
            errors++; $display("FAIL reset_out_port: got %h want %h", op0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL reset_out_update: got %b want %0h", up0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL reset_read_addr0: got %h want %h", rd0, exp_v);
        end
        address = 4'd3;
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL reset_read_addr3: got %h want %h", rd0, exp_v);
        end
    endtask

    task automatic test_shadow_commit;
        bus_write(0, 4'd4, 32'h0123_4567);
        exp_q.push_back(128'(32'h0123_4567));
        exp_q.push_back(128'(27'h88D1));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL shadow_read_ch1: got %h want %h", rd0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op0[27 +: 27]) !== exp_v) begin
            errors++; $display("FAIL shadow_hold_ch1: got %h want %h", op0[27 +: 27], exp_v);
        end
        bus_write(0, 4'd7, 32'h0);
        exp_q.push_back(128'(27'h123_4567));
        exp_q.push_back(128'(4'b0010));
        exp_q.push_back(128'(32'h0123_4567));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op0[27 +: 27]) !== exp_v) begin
            errors++; $display("FAIL commit_ch1: got %h want %h", op0[27 +: 27], exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL commit_update_ch1: got %b want %0h", up0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL commit_read_active_ch1: got %h want %h", rd0, exp_v);
        end
        bus_idle(4'd7);
        exp_q.push_back(128'(4'b0000));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL commit_update_drop: got %b want %0h", up0, exp_v);
        end
    endtask

    task automatic test_set_clear;
        bus_write(0, 4'd1, 32'h0000_00F0);
        exp_q.push_back(128'(32'h0000_88F1));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL set_read_ch0: got %h want %h", rd0, exp_v);
        end
        bus_write(0, 4'd2, 32'h0000_0030);
        bus_write(0, 4'd3, 32'h0);
        exp_q.push_back(128'(27'h88C1));
        exp_q.push_back(128'(4'b0001));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op0[0 +: 27]) !== exp_v) begin
            errors++; $display("FAIL set_clear_commit_ch0: got %h want %h", op0[0 +: 27], exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL set_clear_update: got %b want %0h", up0, exp_v);
        end
        bus_idle(4'd0);
    endtask

    task automatic test_truncation;
        bus_write(0, 4'd8, 32'hFFFF_FFFF);
        bus_write(0, 4'd11, 32'h0);
        exp_q.push_back(128'(27'h7FF_FFFF));
        exp_q.push_back(128'(32'h07FF_FFFF));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op0[54 +: 27]) !== exp_v) begin
            errors++; $display("FAIL trunc_slice_ch2: got %h want %h", op0[54 +: 27], exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL trunc_read_ch2: got %h want %h", rd0, exp_v);
        end
        bus_idle(4'd0);
    endtask

    task automatic test_back_to_back;
        bus_write(0, 4'd3, 32'h0);
        exp_q.push_back(128'(4'b0001));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL b2b_first_pulse: got %b want %0h", up0, exp_v);
        end
        bus_write(0, 4'd3, 32'h0);
        exp_q.push_back(128'(4'b0001));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL b2b_second_pulse: got %b want %0h", up0, exp_v);
        end
        bus_idle(4'd0);
        exp_q.push_back(128'(4'b0000));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL b2b_pulse_end: got %b want %0h", up0, exp_v);
        end
    endtask

    task automatic test_no_shadow;
        bus_write(1, 4'd12, 32'h0000_0005);
        exp_q.push_back(128'(27'h5));
        exp_q.push_back(128'(4'b1000));
        exp_q.push_back(128'({3{27'h88D1}}));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op1[81 +: 27]) !== exp_v) begin
            errors++; $display("FAIL direct_slice_ch3: got %h want %h", op1[81 +: 27], exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up1) !== exp_v) begin
            errors++; $display("FAIL direct_update_ch3: got %b want %0h", up1, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op1[80:0]) !== exp_v) begin
            errors++; $display("FAIL direct_other_ch: got %h want %h", op1[80:0], exp_v);
        end
        bus_idle(4'd12);
        exp_q.push_back(128'(4'b0000));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up1) !== exp_v) begin
            errors++; $display("FAIL direct_update_drop: got %b want %0h", up1, exp_v);
        end
    endtask

    task automatic test_out_of_range;
        bus_write(2, 4'd12, 32'h0000_0005);
        exp_q.push_back(128'({3{27'h88D1}}));
        exp_q.push_back(128'(3'b000));
        exp_q.push_back(128'(32'h0));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op2) !== exp_v) begin
            errors++; $display("FAIL oor_out_port: got %h want %h", op2, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up2) !== exp_v) begin
            errors++; $display("FAIL oor_update: got %b want %0h", up2, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd2) !== exp_v) begin
            errors++; $display("FAIL oor_read: got %h want %h", rd2, exp_v);
        end
        bus_idle(4'd12);
    endtask

    task automatic test_reset_commit;
        bus_write(0, 4'd0, 32'h0000_1234);
        @(negedge clk);
        reset   = 1'b1;
        address = 4'd3;
        @(posedge clk);
        #1;
        exp_q.push_back(128'(27'h88D1));
        exp_q.push_back(128'(4'b0000));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(op0[0 +: 27]) !== exp_v) begin
            errors++; $display("FAIL rst_commit_ch0: got %h want %h", op0[0 +: 27], exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL rst_commit_update: got %b want %0h", up0, exp_v);
        end
        @(negedge clk);
        reset   = 1'b0;
        cs      = 3'b000;
        write_n = 1'b1;
        address = 4'd0;
        @(posedge clk);
        #1;
        exp_q.push_back(128'(32'h0000_88D1));
        exp_q.push_back(128'(4'b0000));
        exp_v = exp_q.pop_front(); checks++;
        if (128'(rd0) !== exp_v) begin
            errors++; $display("FAIL rst_discard_shadow: got %h want %h", rd0, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (128'(up0) !== exp_v) begin
            errors++; $display("FAIL rst_after_update: got %b want %0h", up0, exp_v);
        end
    endtask

    initial begin
        reset     = 1'b1;
        cs        = 3'b000;
        write_n   = 1'b1;
        address   = 4'd0;
        writedata = 32'h0;
        test_reset();
        test_shadow_commit();
        test_set_clear();
        test_truncation();
        test_back_to_back();
        test_no_shadow();
        test_out_of_range();
        test_reset_commit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pio_bank.md
# pio_bank

Parametrised multi-channel Avalon-MM output PIO, the successor to the single fixed-width 27-bit output PIO in the Computer_System. It sits on the HPS lightweight bridge and drives parameter words (coordinates, iteration limits, control bits) into the Mandelbrot solver fabric. Each channel adds bit-set and bit-clear access, an optional shadow/commit stage so multi-word parameter sets update atomically, and a one-cycle update strobe to the fabric.

## Interface
Parameters:
- DATA_W, 27: width of each channel, 1..32.
- CHANNELS, 4: number of output channels, 1..16.
- RESET_VALUE, 35025: reset value of every channel's shadow and active registers, truncated to DATA_W.
- SHADOW, 1: 1 = writes land in a shadow register and reach out_port only on commit; 0 = writes reach out_port directly.
- ADDR_W, clog2(CHANNELS)+2: derived; do not override.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address; address[ADDR_W-1:2] = channel, address[1:0] = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above DATA_W ignored.
- readdata  out  32  read data, zero-extended above DATA_W.
- out_port  out  CHANNELS*DATA_W  active values; channel k at [k*DATA_W +: DATA_W].
- out_update  out  CHANNELS  one-cycle pulse per channel when its active value is loaded.

## Operation
- Per channel: shadow register S and active register A, both DATA_W.
- Write is chipselect && !write_n. Channel index >= CHANNELS: write ignored, read returns 0.
- Register 0, DATA: write S <= wd. Read returns S.
- Register 1, SET: write S <= S | wd. Read returns S.
- Register 2, CLEAR: write S <= S & ~wd. Read returns S.
- Register 3, COMMIT: write with any data sets A <= S. Read returns A.
- SHADOW=0: every write to registers 0-2 also loads A with the new S value in the same edge. COMMIT write still loads A <= S and pulses out_update.
- out_update[k] is registered and goes high for exactly one cycle after any edge that loaded A[k]. It is asserted even if the value is unchanged.
- Reset: S = A = RESET_VALUE[DATA_W-1:0] for all channels; out_update = 0; out_port = replicated RESET_VALUE. Reset takes priority over a coincident write. Reset mid-sequence discards uncommitted shadow data.
- readdata is combinational from address, ignoring chipselect, matching existing PIO read behaviour. It is zero when the channel is out of range.

## Timing
- Write at edge N:
  - S is visible on readdata after edge N.
  - SHADOW=0: A and out_port change after edge N, and out_update is high during cycle N+1.
- COMMIT at edge M: out_port changes after edge M; out_update[k] is high during cycle M+1 only.
- Back-to-back COMMITs at edges M and M+1 hold out_update high for cycles M+1 and M+2 (two pulses, contiguous).
- SET/CLEAR are read-modify-write on S within a single edge. Consecutive SET at N and CLEAR at N+1 see the updated S.
- No wait states; every access completes in one cycle.

## Test plan
- Reset, DATA_W=27, CHANNELS=4, SHADOW=1 -> every out_port slice = 0x88D1 (35025); out_update = 0; reading address 0 and address 3 returns 0x000088D1.
- SHADOW=1: write 0x0123_4567 to ch1 DATA, read ch1 DATA -> 0x0123_4567. ch1 out_port stays 0x88D1 until ch1 COMMIT. After COMMIT: slice = 0x0123_4567 and out_update = 4'b0010 for one cycle.
- SET 0x0000_00F0 then CLEAR 0x0000_0030 on ch0 (S = 0x88D1), then COMMIT -> A = 0x88F1 & ~0x30 = 0x88C1.
- writedata 0xFFFF_FFFF to ch2 DATA then COMMIT -> slice = 0x7FF_FFFF and readdata = 0x07FF_FFFF (upper bits zero).
- SHADOW=0: write 0x5 to ch3 DATA -> ch3 out_port = 0x5 after the edge, out_update[3] pulses. CHANNELS=3: write to ch3 -> no change anywhere, read returns 0.
- Reset asserted on the same edge as ch0 COMMIT of a pending 0x1234 -> ch0 stays 0x88D1, no out_update pulse.
